wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/simple_processor_pkg.sv | 29 ++
 rtl/wb_regfile_if.sv | 31 +++
 rtl/wb_regfile_sel.sv | 28 ++
 rtl/wb_regfile.sv | 115 +++++++++++
 tb/tb_wb_regfile.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_processor_pkg.sv
// Shared processor types and sizing: datapath width, register count and the
// execute-unit operation encoding consumed by the writeback register file.
package simple_processor_pkg;

  localparam int DATAWIDTH = 32;
  localparam int NUM_REG   = 32;

  // Encodings above SLRI (including INVALID) are treated as non-operations.
  typedef enum logic [3:0] {
    ADD     = 4'd0,
    ADDI    = 4'd1,
    SUB     = 4'd2,
    AND     = 4'd3,
    OR      = 4'd4,
    XOR     = 4'd5,
    NOT     = 4'd6,
    SLL     = 4'd7,
    SLLI    = 4'd8,
    SLR     = 4'd9,
    SLRI    = 4'd10,
    INVALID = 4'd11
  } func_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback request bus between the execute stage (master) and the register
// file (slave): valid/ready handshake, destination, operation and results.
interface wb_regfile_if
  import simple_processor_pkg::*;
#(
  parameter int DATAWIDTH = simple_processor_pkg::DATAWIDTH,
  parameter int ADDRW     = $clog2(simple_processor_pkg::NUM_REG)
) ();

  logic                 wb_valid_i;
  logic                 wb_ready_o;
  func_t                wb_func_i;
  logic [ADDRW-1:0]     wb_rd_i;
  logic [DATAWIDTH-1:0] res_math_i;
  logic [DATAWIDTH-1:0] res_gate_i;
  logic [DATAWIDTH-1:0] res_shift_i;
  logic                 wb_stall_i;

  modport master (
    output wb_valid_i, wb_func_i, wb_rd_i,
    output res_math_i, res_gate_i, res_shift_i, wb_stall_i,
    input  wb_ready_o
  );

  modport slave (
    input  wb_valid_i, wb_func_i, wb_rd_i,
    input  res_math_i, res_gate_i, res_shift_i, wb_stall_i,
    output wb_ready_o
  );

endinterface

// File: rtl/wb_regfile_sel.sv
// Picks which execute-unit result belongs to an operation; flags encodings
// that do not name a real operation so the caller can discard them.
module wb_sel
  import simple_processor_pkg::*;
#(
  parameter int DATAWIDTH = simple_processor_pkg::DATAWIDTH
) (
  input  func_t                func_i,
  input  logic [DATAWIDTH-1:0] res_math_i,
  input  logic [DATAWIDTH-1:0] res_gate_i,
  input  logic [DATAWIDTH-1:0] res_shift_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 valid_op_o
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    data_o     = '0;
    valid_op_o = 1'b1;
    case (func_i)
      ADD, ADDI, SUB:       data_o = res_math_i;
      AND, OR, XOR, NOT:    data_o = res_gate_i;
      SLL, SLLI, SLR, SLRI: data_o = res_shift_i;
      default:              valid_op_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Register file with a one-entry writeback buffer: results are accepted into
// the buffer, committed one edge later unless stalled, and forwarded to reads.
module wb_regfile
  import simple_processor_pkg::*;
#(
  parameter int  DATAWIDTH = simple_processor_pkg::DATAWIDTH,
  parameter int  NUM_REG   = simple_processor_pkg::NUM_REG,
  localparam int ADDRW     = $clog2(NUM_REG)
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [ADDRW-1:0]     rs1_addr_i,
  input  logic [ADDRW-1:0]     rs2_addr_i,
  output logic [DATAWIDTH-1:0] rs1_data_o,
  output logic [DATAWIDTH-1:0] rs2_data_o,
  wb_regfile_if.slave          wb,
  output logic [15:0]          wb_count_o,
  output logic                 invalid_o
);

  typedef struct packed {
    logic                 pending;
    logic [ADDRW-1:0]     rd;
    logic [DATAWIDTH-1:0] data;
  } wb_entry_t;

  buf_state_t           r_state;
  buf_state_t           w_state_next;
  wb_entry_t            r_entry;
  logic [DATAWIDTH-1:0] r_regs [NUM_REG];
  logic [15:0]          r_count;
  logic                 r_invalid;

  logic [DATAWIDTH-1:0] w_sel_data;
  logic                 w_valid_op;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_fill;
  logic                 w_commit;
  logic                 w_fwd1;
  logic                 w_fwd2;

  wb_sel #(.DATAWIDTH(DATAWIDTH)) u_sel (
    .func_i      (wb.wb_func_i),
    .res_math_i  (wb.res_math_i),
    .res_gate_i  (wb.res_gate_i),
    .res_shift_i (wb.res_shift_i),
    .data_o      (w_sel_data),
    .valid_op_o  (w_valid_op)
  );

  assign w_full         = (r_state == BUF_FULL);
  assign wb.wb_ready_o  = !w_full || !wb.wb_stall_i;
  assign w_accept       = wb.wb_valid_i && wb.wb_ready_o;
  assign w_fill         = w_accept && w_valid_op;
  assign w_commit       = w_full && !wb.wb_stall_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUF_EMPTY: if (w_fill) w_state_next = BUF_FULL;
      BUF_FULL:  if (w_commit && !w_fill) w_state_next = BUF_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the array is reset explicitly because register contents after reset are architecturally visible.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      r_entry   <= '0;
      r_count   <= '0;
      r_invalid <= 1'b0;
      for (int i = 0; i < NUM_REG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_fill) begin
        r_entry <= '{pending: 1'b1, rd: wb.wb_rd_i, data: w_sel_data};
      end else if (w_commit) begin
        r_entry.pending <= 1'b0;
      end

      // Writes to register 0 still count as commits but leave the array alone.
      if (w_commit) begin
        r_count <= r_count + 16'd1;
        if (r_entry.rd != '0) begin
          r_regs[r_entry.rd] <= r_entry.data;
        end
      end

      if (w_accept && !w_valid_op) begin
        r_invalid <= 1'b1;
      end
    end
  end

  // A buffered entry is newer than the array, so it wins on a matching read.
  assign w_fwd1 = r_entry.pending && (r_entry.rd == rs1_addr_i) && (rs1_addr_i != '0);
  assign w_fwd2 = r_entry.pending && (r_entry.rd == rs2_addr_i) && (rs2_addr_i != '0);

  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : (w_fwd1 ? r_entry.data : r_regs[rs1_addr_i]);
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : (w_fwd2 ? r_entry.data : r_regs[rs2_addr_i]);

  assign wb_count_o = r_count;
  assign invalid_o  = r_invalid;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by random traffic, all
// compared against a queue-based model of pending writebacks.
module tb_wb_regfile;
  import simple_processor_pkg::*;

  localparam int DW = DATAWIDTH;
  localparam int NR = NUM_REG;
  localparam int AW = $clog2(NR);

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } m_entry_t;

  logic          clk_i   = 1'b0;
  logic          arst_ni = 1'b0;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [15:0]   wb_count;
  logic          invalid;

  wb_regfile_if #(.DATAWIDTH(DW), .ADDRW(AW)) wb ();

  wb_regfile #(.DATAWIDTH(DW), .NUM_REG(NR)) dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .wb         (wb),
    .wb_count_o (wb_count),
    .invalid_o  (invalid)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [DW-1:0] m_regs [NR];
  m_entry_t    m_q [$];
  logic [15:0] m_count;
  logic        m_inv;

  function automatic logic [DW-1:0] m_pick(func_t f, logic [DW-1:0] m, logic [DW-1:0] g,
                                           logic [DW-1:0] s, output bit listed);
    listed = 1'b1;
    if (f inside {ADD, ADDI, SUB}) return m;
    if (f inside {AND, OR, XOR, NOT}) return g;
    if (f inside {SLL, SLLI, SLR, SLRI}) return s;
    listed = 1'b0;
    return '0;
  endfunction

  function automatic logic m_ready();
    return (m_q.size() == 0) || !wb.wb_stall_i;
  endfunction

  function automatic logic [DW-1:0] m_read(logic [AW-1:0] a);
    if (a == '0) return '0;
    if (m_q.size() != 0 && m_q[0].rd == a) return m_q[0].data;
    return m_regs[a];
  endfunction

  task automatic model_edge();
    bit            listed;
    bit            rdy;
    logic [DW-1:0] d;
    m_entry_t      e;
    if (!arst_ni) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_q.delete();
      m_count = '0;
      m_inv   = 1'b0;
      return;
    end
    rdy = m_ready();
    if (m_q.size() != 0 && !wb.wb_stall_i) begin
      e = m_q.pop_front();
      if (e.rd != '0) m_regs[e.rd] = e.data;
      m_count = m_count + 16'd1;
    end
    if (wb.wb_valid_i && rdy) begin
      d = m_pick(wb.wb_func_i, wb.res_math_i, wb.res_gate_i, wb.res_shift_i, listed);
      if (listed) m_q.push_back('{rd: wb.wb_rd_i, data: d});
      else m_inv = 1'b1;
    end
  endtask

  task automatic drive(bit v, func_t f, logic [AW-1:0] rd, logic [DW-1:0] m,
                       logic [DW-1:0] g, logic [DW-1:0] s, bit st);
    wb.wb_valid_i  = v;
    wb.wb_func_i   = f;
    wb.wb_rd_i     = rd;
    wb.res_math_i  = m;
    wb.res_gate_i  = g;
    wb.res_shift_i = s;
    wb.wb_stall_i  = st;
  endtask

  task automatic idle(bit st);
    drive(1'b0, ADD, '0, '0, '0, '0, st);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    #1;
    check({tag, ".ready"}, DW'(wb.wb_ready_o), DW'(m_ready()));
    check({tag, ".rs1"}, rs1_data, m_read(rs1_addr));
    check({tag, ".rs2"}, rs2_data, m_read(rs2_addr));
    check({tag, ".count"}, DW'(wb_count), DW'(m_count));
    check({tag, ".invalid"}, DW'(invalid), DW'(m_inv));
  endtask

  initial begin
    int n;
    rs1_addr = '0;
    rs2_addr = '0;
    idle(1'b0);

    // Reset, then every address reads zero.
    tick();
    tick();
    arst_ni = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(NR - 1 - i);
      #1;
      check("reset_rd1", rs1_data, '0);
      check("reset_rd2", rs2_data, '0);
    end
    check("reset_ready", DW'(wb.wb_ready_o), DW'(1));
    check("reset_count", DW'(wb_count), '0);
    check("reset_invalid", DW'(invalid), '0);

    // ADD into r5: forwarded the cycle after accept, then from the array.
    drive(1'b1, ADD, 5, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle(1'b0);
    rs1_addr = 5;
    check_all("add_fwd");
    check("add_fwd_val", rs1_data, 32'h0000_1234);
    tick();
    check_all("add_commit");
    check("add_commit_val", rs1_data, 32'h0000_1234);
    check("add_count", DW'(wb_count), DW'(1));

    // XOR into r7 while stalled: buffer held, ready low, forwarding active.
    drive(1'b1, XOR, 7, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b1);
    check_all("xor_accept");
    tick();
    idle(1'b1);
    rs2_addr = 7;
    check_all("xor_stall");
    check("xor_ready_low", DW'(wb.wb_ready_o), '0);
    check("xor_fwd", rs2_data, 32'hA5A5_A5A5);
    tick();
    check_all("xor_stall2");
    check("xor_count_held", DW'(wb_count), DW'(1));
    idle(1'b0);
    tick();
    check_all("xor_release");
    check("xor_count", DW'(wb_count), DW'(2));

    // Back-to-back shifts into r3.
    drive(1'b1, SLL, 3, '0, '0, 32'd1, 1'b0);
    tick();
    drive(1'b1, SLRI, 3, '0, '0, 32'd2, 1'b0);
    rs1_addr = 3;
    check_all("shift_b2b1");
    check("shift_ready", DW'(wb.wb_ready_o), DW'(1));
    check("shift_rd1", rs1_data, 32'd1);
    tick();
    idle(1'b0);
    check_all("shift_b2b2");
    check("shift_rd2", rs1_data, 32'd2);
    tick();
    check("shift_count", DW'(wb_count), DW'(4));

    // Write to r0 commits but reads stay zero; INVALID only sets the flag.
    drive(1'b1, AND, 0, '0, 32'hFFFF_FFFF, '0, 1'b0);
    tick();
    idle(1'b0);
    rs1_addr = 0;
    check_all("r0_write");
    tick();
    check("r0_read", rs1_data, '0);
    check("r0_count", DW'(wb_count), DW'(5));
    drive(1'b1, INVALID, 4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0);
    tick();
    idle(1'b0);
    rs1_addr = 4;
    check_all("invalid_op");
    tick();
    check("invalid_flag", DW'(invalid), DW'(1));
    check("invalid_r4", rs1_data, '0);
    check("invalid_count", DW'(wb_count), DW'(5));

    // Counter wrap: bring to FFFF with back-to-back commits, then one more.
    n = 16'hFFFF - int'(m_count);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, ADDI, AW'(k % (NR - 1) + 1), DW'(k), '0, '0, 1'b0);
      tick();
    end
    idle(1'b0);
    tick();
    check_all("wrap_pre");
    check("count_ffff", DW'(wb_count), DW'(16'hFFFF));
    drive(1'b1, SUB, 2, 32'h77, '0, '0, 1'b0);
    tick();
    idle(1'b0);
    tick();
    check_all("wrap_post");
    check("count_wrap", DW'(wb_count), '0);

    // Reset while FULL drops the entry; a same-edge accept is ignored.
    drive(1'b1, ADD, 9, 32'h5555_5555, '0, '0, 1'b0);
    tick();
    arst_ni = 1'b0;
    drive(1'b1, ADD, 10, 32'h7777_7777, '0, '0, 1'b0);
    tick();
    idle(1'b0);
    rs1_addr = 9;
    rs2_addr = 10;
    check_all("rst_full");
    check("rst_ready", DW'(wb.wb_ready_o), DW'(1));
    arst_ni = 1'b1;
    tick();
    check_all("rst_after");
    check("rst_r9", rs1_data, '0);
    check("rst_r10", rs2_data, '0);

    // Random traffic, including unlisted encodings, stalls and rare resets.
    for (int c = 0; c < 600; c++) begin
      arst_ni = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 1)), func_t'(4'($urandom_range(0, 15))),
            AW'($urandom_range(0, NR - 1)), DW'($urandom), DW'($urandom), DW'($urandom),
            $urandom_range(0, 9) < 3);
      rs1_addr = AW'($urandom_range(0, NR - 1));
      rs2_addr = (c % 2 == 0) ? wb.wb_rd_i : AW'($urandom_range(0, NR - 1));
      check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
